ldst_mem_port: RTL and testbench

//  Responder side of the execute stage's load/store strobes (ldst_rd / ldst_wr).
//  - Captures one memory op per instruction and runs it on a req/ack data-memory bus

---
 rtl/ldst_mem_port.sv | 142 ++++++++++++++
 tb/tb_ldst_mem_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_mem_port.sv
// Load/store responder: runs one memory op per instruction on a req/ack bus,
// stalls the pipeline while it is outstanding and returns load data to writeback.
module ldst_mem_port #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int REG_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_ldst_rd,
  input  logic              i_ldst_wr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_W-1:0]  i_dst,
  output logic              o_stall,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wb_valid,
  output logic [DATA_W-1:0] o_wb_data,
  output logic [REG_W-1:0]  o_wb_dst,
  output logic              o_err
);

  // state | meaning: IDLE wait for strobe | REQ request on bus | DONE writeback, release stall
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REG_W-1:0]    dst_q, dst_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [REG_W-1:0]    wb_dst_q, wb_dst_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dst_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dst_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dst_q      <= dst_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_dst_q   <= wb_dst_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dst_d      = dst_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_dst_d   = wb_dst_q;
    err_d      = err_q;
    o_stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_ldst_rd || i_ldst_wr) begin
          o_stall = 1'b1;
          addr_d  = i_addr;
          wdata_d = i_wdata;
          dst_d   = i_dst;
          we_d    = ~i_ldst_rd;
          cnt_d   = CNT_W'(TIMEOUT - 1);
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        o_stall = 1'b1;
        if (i_mem_ack) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = i_mem_rdata;
            wb_dst_d   = dst_q;
          end
        end else if (cnt_q == '0) begin
          // abort: ack never came; a load still retires with zero data
          err_d   = 1'b1;
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) begin
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            wb_dst_d   = dst_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_mem_req   = req_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_wb_valid  = wb_valid_q;
  assign o_wb_data   = wb_data_q;
  assign o_wb_dst    = wb_dst_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_ldst_mem_port.sv
// Scoreboard bench for ldst_mem_port: stimulus pushes expected bus transactions,
// stall lengths and writebacks; a monitor pops and compares them as the DUT emits them.
module tb_ldst_mem_port;

  localparam int TIMEOUT = 15;

  typedef struct {logic [15:0] addr; logic we; logic [15:0] wdata;} mem_t;
  typedef struct {int cycles; logic err;} req_t;
  typedef struct {logic [15:0] data; logic [2:0] dst;} wb_t;
  typedef struct {int delay; logic [15:0] rdata;} resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_ldst_rd, i_ldst_wr;
  logic [15:0] i_addr, i_wdata;
  logic [2:0]  i_dst;
  logic        o_stall, o_mem_req, o_mem_we;
  logic [15:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [15:0] i_mem_rdata;
  logic        o_wb_valid;
  logic [15:0] o_wb_data;
  logic [2:0]  o_wb_dst;
  logic        o_err;

  mem_t  exp_mem[$];
  req_t  exp_req[$];
  int    exp_stall[$];
  wb_t   exp_wb[$];
  resp_t resp_q[$];

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic m_err = 1'b0;

  ldst_mem_port #(.DATA_W(16), .ADDR_W(16), .REG_W(3), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_ldst_rd(i_ldst_rd), .i_ldst_wr(i_ldst_wr),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_dst(i_dst),
    .o_stall(o_stall),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data), .o_wb_dst(o_wb_dst),
    .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(string name, string msg);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Reference model: an op is fully described by its strobes and how long memory waits.
  task automatic issue(bit rd, bit wr, logic [15:0] a, logic [15:0] wd, logic [2:0] dst,
                       int delay, logic [15:0] rdat);
    mem_t m;
    req_t r;
    wb_t  w;
    resp_t rs;
    bit timed_out;
    int rc;
    int n;
    timed_out = (delay + 1 > TIMEOUT);
    rc = timed_out ? TIMEOUT : delay + 1;
    if (timed_out) m_err = 1'b1;
    m.addr = a; m.we = !rd; m.wdata = wd;
    exp_mem.push_back(m);
    r.cycles = rc; r.err = m_err;
    exp_req.push_back(r);
    exp_stall.push_back(1 + rc);
    if (rd) begin
      w.data = timed_out ? 16'h0000 : rdat;
      w.dst  = dst;
      exp_wb.push_back(w);
    end
    rs.delay = delay; rs.rdata = rdat;
    resp_q.push_back(rs);
    i_ldst_rd = rd; i_ldst_wr = wr; i_addr = a; i_wdata = wd; i_dst = dst;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_stall && n < 100);
    if (n >= 100) flag("stall_release", "stall never dropped");
  endtask

  // 0: next op immediately, 1: strobe held through DONE, >=2: idle gap
  task automatic gap(int g);
    if (g == 1) begin
      @(negedge clk);
    end else if (g >= 2) begin
      i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
      repeat (g - 1) @(negedge clk);
    end
  endtask

  // memory responder
  initial begin
    resp_t r;
    int cnt;
    cnt = 0;
    r.delay = 100; r.rdata = 16'h0;
    i_mem_ack = 1'b0; i_mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      if (o_mem_req) begin
        if (cnt == 0) begin
          if (resp_q.size() == 0) begin
            flag("unexpected_req", "memory request with no op issued");
            r.delay = 100; r.rdata = 16'h0;
          end else begin
            r = resp_q.pop_front();
          end
        end
        cnt++;
        i_mem_ack   = (cnt == r.delay + 1);
        i_mem_rdata = i_mem_ack ? r.rdata : 16'($urandom);
      end else begin
        cnt = 0;
        i_mem_ack   = ($urandom_range(0, 3) == 0);
        i_mem_rdata = 16'($urandom);
      end
    end
  end

  // monitor / scoreboard
  initial begin
    mem_t cur;
    req_t r;
    wb_t  w;
    int   es;
    bit   prev_req, prev_stall, stable;
    int   req_cnt, stall_cnt;
    prev_req = 0; prev_stall = 0; stable = 1; req_cnt = 0; stall_cnt = 0;
    cur.addr = 0; cur.we = 0; cur.wdata = 0;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (o_mem_req && !prev_req) begin
          req_cnt = 0; stable = 1;
          if (exp_mem.size() == 0) flag("mem_txn", "request with empty expectation queue");
          else begin
            cur = exp_mem.pop_front();
            check("mem_addr", o_mem_addr, cur.addr);
            check("mem_we", o_mem_we, cur.we);
            check("mem_wdata", o_mem_wdata, cur.wdata);
          end
        end else if (o_mem_req && (o_mem_addr !== cur.addr || o_mem_we !== cur.we ||
                                   o_mem_wdata !== cur.wdata)) begin
          stable = 0;
        end
        if (o_mem_req) req_cnt++;
        if (!o_mem_req && prev_req) begin
          if (exp_req.size() == 0) flag("req_end", "request ended with empty queue");
          else begin
            r = exp_req.pop_front();
            check("req_cycles", req_cnt, r.cycles);
            check("err_after_op", o_err, r.err);
            check("req_stable", stable, 1'b1);
          end
        end
        if (o_stall) stall_cnt++;
        else if (prev_stall) begin
          if (exp_stall.size() == 0) flag("stall_len", "stall run with empty queue");
          else begin
            es = exp_stall.pop_front();
            check("stall_len", stall_cnt, es);
          end
          stall_cnt = 0;
        end
        if (o_wb_valid) begin
          check("wb_timing", {31'd0, prev_req && !o_mem_req}, 32'd1);
          if (exp_wb.size() == 0) flag("wb_unexpected", "wb_valid with no load pending");
          else begin
            w = exp_wb.pop_front();
            check("wb_data", o_wb_data, w.data);
            check("wb_dst", o_wb_dst, w.dst);
          end
        end
      end else begin
        stall_cnt = 0; req_cnt = 0;
      end
      prev_req = o_mem_req; prev_stall = o_stall;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    reset = 1'b1;
    i_ldst_rd = 1'b0; i_ldst_wr = 1'b0; i_addr = 16'h0; i_wdata = 16'h0; i_dst = 3'h0;
    repeat (3) @(negedge clk);
    check("rst_req", o_mem_req, 1'b0);
    check("rst_we", o_mem_we, 1'b0);
    check("rst_addr", o_mem_addr, 16'h0);
    check("rst_wdata", o_mem_wdata, 16'h0);
    check("rst_wb_valid", o_wb_valid, 1'b0);
    check("rst_wb_data", o_wb_data, 16'h0);
    check("rst_err", o_err, 1'b0);
    check("rst_stall", o_stall, 1'b0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    issue(1'b1, 1'b0, 16'h0040, 16'h0000, 3'd3, 0, 16'hBEEF);
    gap(2);
    issue(1'b0, 1'b1, 16'h0100, 16'h1234, 3'd0, 4, 16'h5555);
    gap(2);
    issue(1'b1, 1'b0, 16'h0200, 16'h0000, 3'd5, TIMEOUT - 1, 16'hCAFE);
    gap(0);
    issue(1'b1, 1'b1, 16'h0300, 16'hDEAD, 3'd6, 2, 16'h7777);
    gap(1);
    issue(1'b1, 1'b0, 16'h0400, 16'h0000, 3'd1, TIMEOUT + 5, 16'h9999);
    gap(2);

    for (int i = 0; i < 60; i++) begin
      int k;
      int d;
      k = $urandom_range(0, 2);
      d = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 3, TIMEOUT + 3)
                                      : $urandom_range(0, 5);
      issue(k != 1, k != 0, 16'($urandom), 16'($urandom), 3'($urandom), d, 16'($urandom));
      gap($urandom_range(0, 3));
    end

    i_ldst_rd = 1'b0; i_ldst_wr = 1'b0;
    repeat (4) @(negedge clk);
    check("drain_mem", exp_mem.size(), 0);
    check("drain_req", exp_req.size(), 0);
    check("drain_stall", exp_stall.size(), 0);
    check("drain_wb", exp_wb.size(), 0);
    check("drain_resp", resp_q.size(), 0);
    check("err_sticky", o_err, 1'b1);

    // reset during a long wait: everything drops at once, nothing retires afterwards
    mon_en = 1'b0;
    begin
      resp_t rs;
      rs.delay = 100; rs.rdata = 16'h0;
      resp_q.push_back(rs);
    end
    i_ldst_rd = 1'b1; i_addr = 16'h0500; i_dst = 3'd2;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_req", o_mem_req, 1'b1);
    #1;
    reset = 1'b1;
    i_ldst_rd = 1'b0;
    #1;
    check("async_rst_req", o_mem_req, 1'b0);
    check("async_rst_stall", o_stall, 1'b0);
    check("async_rst_err", o_err, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_wb_valid || o_mem_req) bad++;
    end
    check("no_activity_after_reset", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
